// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flow-controlled FIFO.
package fifo_pkg;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v = value - 1;
        while (v > 0) begin
            res = res + 1;
            v = v >> 1;
        end
        return res;
    endfunction

    localparam int DEPTH_DEF     = 4;
    localparam int WORD_SIZE_DEF = 6;
    localparam int PTR_L_DEF     = clog2(DEPTH_DEF);
    localparam int CNT_L_DEF     = PTR_L_DEF + 1;

endpackage

// File: rtl/fifo_mem_array.sv
// Dual-port storage with a synchronous write port and a registered,
// zero-when-idle read port; everything clears on reset.
module fifo_mem_array #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = 6,
    parameter int PTR_L     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [PTR_L-1:0]     wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [PTR_L-1:0]     rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Read sees the pre-write contents, so a full-FIFO push+pop to the same
    // slot returns the oldest word rather than the incoming one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO: pointer/count management, status flags, sticky errors
// and a registered read port with valid strobe.
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int PTR_L     = PTR_L_DEF,
    parameter int CNT_L     = CNT_L_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [CNT_L-1:0]     af_th,
    input  logic [CNT_L-1:0]     ae_th,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [CNT_L-1:0]     count,
    output logic                 overflow,
    output logic                 underflow
);

    logic [PTR_L:0] wr_ptr;
    logic [PTR_L:0] rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    // Flags come only from registered pointers/count; push/pop never reach outputs.
    assign full  = (wr_ptr[PTR_L] != rd_ptr[PTR_L]) &&
                   (wr_ptr[PTR_L-1:0] == rd_ptr[PTR_L-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign almost_full  = (count >= af_th);
    assign almost_empty = (count <= ae_th);

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            valid <= pop_ok;
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem_array #(
        .DEPTH     (DEPTH),
        .WORD_SIZE (WORD_SIZE),
        .PTR_L     (PTR_L)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr[PTR_L-1:0]),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr[PTR_L-1:0]),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Self-checking bench: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_flow_ctrl;

    localparam int DEPTH = 4;
    localparam int WS    = 6;
    localparam int CL    = 3;

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic [WS-1:0] data_in;
    logic [CL-1:0] af_th;
    logic [CL-1:0] ae_th;
    logic [WS-1:0] data_out;
    logic          valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CL-1:0] count;
    logic          overflow;
    logic          underflow;

    fifo_flow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .af_th        (af_th),
        .ae_th        (ae_th),
        .data_out     (data_out),
        .valid        (valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO content is just a queue.
    logic [WS-1:0] q[$];
    logic          m_valid;
    logic [WS-1:0] m_data;
    logic          m_ovf;
    logic          m_unf;
    logic          live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            live    = 1'b1;
        end else if (live) begin
            automatic bit was_full  = (q.size() == DEPTH);
            automatic bit was_empty = (q.size() == 0);
            automatic bit p_ok = pop && !was_empty;
            automatic bit w_ok = push && (!was_full || p_ok);
            if (p_ok) begin
                m_data  = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_data  = '0;
                m_valid = 1'b0;
            end
            if (w_ok) q.push_back(data_in);
            if (push && !w_ok) m_ovf = 1'b1;
            if (pop && !p_ok) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_data_out", data_out, m_data);
            chk("m_valid", valid, m_valid);
            chk("m_count", count, q.size());
            chk("m_full", full, q.size() == DEPTH);
            chk("m_empty", empty, q.size() == 0);
            chk("m_almost_full", almost_full, q.size() >= int'(af_th));
            chk("m_almost_empty", almost_empty, q.size() <= int'(ae_th));
            chk("m_overflow", overflow, m_ovf);
            chk("m_underflow", underflow, m_unf);
        end
    end

    task automatic cyc(input logic p, input logic r, input logic [WS-1:0] d);
        push    = p;
        pop     = r;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    initial begin
        logic [WS-1:0] w;
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        af_th   = 3'd4;
        ae_th   = 3'd0;
        cyc(1'b0, 1'b0, '0);
        do_reset();

        // Idle after reset
        repeat (3) cyc(1'b0, 1'b0, '0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);

        // Fill and drain in order
        cyc(1'b1, 1'b0, 6'h11);
        cyc(1'b1, 1'b0, 6'h22);
        cyc(1'b1, 1'b0, 6'h33);
        cyc(1'b1, 1'b0, 6'h04);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        cyc(1'b0, 1'b1, '0);
        chk("drain0_valid", valid, 1);
        chk("drain0_data", data_out, 6'h11);
        cyc(1'b0, 1'b1, '0);
        chk("drain1_data", data_out, 6'h22);
        cyc(1'b0, 1'b1, '0);
        chk("drain2_data", data_out, 6'h33);
        cyc(1'b0, 1'b1, '0);
        chk("drain3_valid", valid, 1);
        chk("drain3_data", data_out, 6'h04);
        chk("drain_empty", empty, 1);
        cyc(1'b0, 1'b0, '0);
        chk("drain_idle_valid", valid, 0);
        chk("drain_idle_data", data_out, 0);

        // Overflow: dropped word never appears
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, WS'(i));
        cyc(1'b1, 1'b0, 6'h3F);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b1, '0);
            chk("ovf_pop_data", data_out, i);
        end
        chk("ovf_empty", empty, 1);

        // Push+pop while full
        do_reset();
        for (int i = 5; i <= 8; i++) cyc(1'b1, 1'b0, WS'(i));
        cyc(1'b1, 1'b1, 6'h2A);
        chk("fpp_data", data_out, 6'h05);
        chk("fpp_valid", valid, 1);
        chk("fpp_count", count, 4);
        chk("fpp_ovf", overflow, 0);
        for (int i = 6; i <= 8; i++) begin
            cyc(1'b0, 1'b1, '0);
            chk("fpp_pop_data", data_out, i);
        end
        cyc(1'b0, 1'b1, '0);
        chk("fpp_last_data", data_out, 6'h2A);
        chk("fpp_last_empty", empty, 1);

        // Push+pop while empty: no bypass
        cyc(1'b1, 1'b1, 6'h15);
        chk("epp_unf", underflow, 1);
        chk("epp_valid", valid, 0);
        chk("epp_count", count, 1);
        cyc(1'b0, 1'b1, '0);
        chk("epp_pop_data", data_out, 6'h15);
        chk("epp_pop_valid", valid, 1);

        // Thresholds
        do_reset();
        af_th = 3'd3;
        ae_th = 3'd1;
        cyc(1'b1, 1'b0, 6'h01);
        chk("th1_ae", almost_empty, 1);
        chk("th1_af", almost_full, 0);
        cyc(1'b1, 1'b0, 6'h02);
        chk("th2_ae", almost_empty, 0);
        chk("th2_af", almost_full, 0);
        cyc(1'b1, 1'b0, 6'h03);
        chk("th3_af", almost_full, 1);
        af_th = 3'd0;
        #1;
        chk("th_af_zero", almost_full, 1);
        af_th = 3'd3;

        // Interleaved push/pop wraps pointers twice
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, WS'(6'h30 + i));
            cyc(1'b0, 1'b1, '0);
            w = (i < 3) ? WS'(i + 1) : WS'(6'h30 + i - 3);
            chk("wrap_data", data_out, w);
        end

        // Randomised traffic with occasional threshold changes and resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) af_th = CL'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ae_th = CL'($urandom_range(0, 7));
            reset = ($urandom_range(0, 199) == 0);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WS'($urandom));
            reset = 1'b0;
        end

        // Mid-stream reset discards content and pending read
        cyc(1'b1, 1'b0, 6'h2B);
        cyc(1'b1, 1'b0, 6'h2C);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 6'h2D);
        reset = 1'b0;
        chk("mrst_count", count, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_data", data_out, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_unf", underflow, 0);

        cyc(1'b0, 1'b0, '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
